ethernet_packet_dispatcher: RTL

- Consumes the 9-bit merged byte stream produced by the switch's receive-side packet pusher and delivers each packet to one or more transmit queue slots.
- Each packet is buffered whole, then replayed to every slot named in its header byte.
- The upstream stream has no backpressure, so the block absorbs or drops. Packets that overflow the buffer, and runt packets, are discarded and counted.

---
 rtl/ethernet_packet_dispatcher.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ethernet_packet_dispatcher.sv
// Ethernet packet dispatcher.
// Buffers each incoming packet from the merged 9-bit receive stream, commits it
// once its last byte has arrived, then replays the payload to every transmit
// queue slot selected by the packet's header byte. Overflowing packets and runt
// packets (header only) are discarded and counted.
module ethernet_packet_dispatcher #(
  parameter int TRANSMIT_QUE_SLOTS = 4,
  parameter int BUFFER_DEPTH       = 2048
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [8:0]                          pushed_data,
  input  logic                                pushed_data_valid,
  output logic [TRANSMIT_QUE_SLOTS-1:0][7:0]  transmit_data,
  output logic [TRANSMIT_QUE_SLOTS-1:0]       transmit_data_valid,
  output logic [TRANSMIT_QUE_SLOTS-1:0]       transmit_data_last,
  input  logic [TRANSMIT_QUE_SLOTS-1:0]       transmit_ready,
  output logic [15:0]                         dropped_packets,
  output logic                                buffer_empty
);

  localparam int AW = $clog2(BUFFER_DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [TRANSMIT_QUE_SLOTS-1:0] slot_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    STREAM
  } rd_state_t;

  // Packet storage: bit 8 is the last-byte flag, bits 7:0 the byte.
  logic [8:0] mem [BUFFER_DEPTH];

  // Write side
  ptr_t  wr_ptr;        // speculative: advances on every stored byte
  ptr_t  commit_ptr;    // end of the newest complete packet
  logic  drop_mode;     // discarding the rest of an overflowed packet
  logic  at_header;     // next incoming byte is a header byte
  logic  in_last;
  logic  full;
  logic  wr_en;
  logic  drop_evt;

  // Read side
  rd_state_t state, state_n;
  ptr_t      rd_ptr, rd_ptr_n;
  slot_vec_t mask, mask_n;
  logic [8:0] rd_word;
  logic       xfer;

  assign in_last = pushed_data[8];

  // One slot stays unused so that full and empty are distinguishable.
  assign full     = ((wr_ptr + ptr_t'(1)) == rd_ptr);
  assign wr_en    = pushed_data_valid && !drop_mode && !full;
  assign drop_evt = pushed_data_valid && !drop_mode && (full || (at_header && in_last));

  // Buffer write port.
  // NOTE: the packet RAM has no reset; stale contents are never read because
  // the reader only walks bytes between rd_ptr and commit_ptr.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= pushed_data;
  end

  // Write pointers, overflow/runt handling and the saturating drop counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of all others.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      drop_mode       <= 1'b0;
      at_header       <= 1'b1;
      dropped_packets <= '0;
    end else begin
      if (drop_evt && (dropped_packets != 16'hFFFF))
        dropped_packets <= dropped_packets + 16'd1;

      if (pushed_data_valid) begin
        at_header <= in_last;
        if (drop_mode) begin
          if (in_last) drop_mode <= 1'b0;
        end else if (full) begin
          // Abandon the partial packet; an overflowing last byte ends it here.
          wr_ptr    <= commit_ptr;
          drop_mode <= !in_last;
        end else if (at_header && in_last) begin
          // Runt: header with no payload is never committed.
          wr_ptr <= commit_ptr;
        end else begin
          wr_ptr <= wr_ptr + ptr_t'(1);
          if (in_last) commit_ptr <= wr_ptr + ptr_t'(1);
        end
      end
    end
  end

  assign rd_word = mem[rd_ptr];
  // With an all-zero mask this is always true, which gives the silent drain.
  assign xfer    = ((transmit_ready & mask) == mask);

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rd_ptr <= '0;
      mask   <= '0;
    end else begin
      state  <= state_n;
      rd_ptr <= rd_ptr_n;
      mask   <= mask_n;
    end
  end

  // Read FSM next-state: wait for a committed packet, latch its mask, stream it.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_n  = state;
    rd_ptr_n = rd_ptr;
    mask_n   = mask;
    case (state)
      IDLE: begin
        if (rd_ptr != commit_ptr) state_n = HEADER;
      end
      HEADER: begin
        mask_n   = rd_word[TRANSMIT_QUE_SLOTS-1:0];
        rd_ptr_n = rd_ptr + ptr_t'(1);
        state_n  = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          rd_ptr_n = rd_ptr + ptr_t'(1);
          if (rd_word[8]) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Transmit outputs: the current byte fanned out to the selected slots.
  always_comb begin
    transmit_data       = '0;
    transmit_data_valid = '0;
    transmit_data_last  = '0;
    if (state == STREAM) begin
      transmit_data_valid = mask;
      transmit_data_last  = rd_word[8] ? mask : '0;
      for (int i = 0; i < TRANSMIT_QUE_SLOTS; i++) transmit_data[i] = rd_word[7:0];
    end
  end

  assign buffer_empty = (state == IDLE) && (rd_ptr == commit_ptr);

endmodule
